// File: rtl/banked_ram_ctrl.sv
// Banked single-port RAM with per-byte write enables and a one-entry read response buffer.
// Latency: a read accepted on edge N presents rsp_valid/rsp_rdata after edge N; writes produce no response.
// Backpressure: req_ready = !rsp_valid || rsp_ready; a held response blocks all new requests.
module banked_ram_ctrl #(
  parameter  int DATA_W     = 32,
  parameter  int BANK_DEPTH = 64,
  parameter  int NUM_BANKS  = 4,
  localparam int ADDR_W     = $clog2(BANK_DEPTH * NUM_BANKS),
  localparam int BE_W       = DATA_W / 8,
  localparam int BANK_W     = $clog2(NUM_BANKS),
  localparam int SEL_W      = (BANK_W > 0) ? BANK_W : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_rw,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [SEL_W-1:0]  rsp_bank
);

  localparam int WORD_W = $clog2(BANK_DEPTH);

  // Reject parameter sets the byte-lane and address split cannot represent.
  if ((DATA_W % 8) != 0 || DATA_W < 8 || BANK_DEPTH < 2 ||
      (BANK_DEPTH & (BANK_DEPTH - 1)) != 0 || NUM_BANKS < 1 ||
      (NUM_BANKS & (NUM_BANKS - 1)) != 0) begin : g_bad_param
    $error("banked_ram_ctrl: illegal parameter combination");
  end

  typedef enum logic {EMPTY, FULL} state_e;

  state_e              state_q;
  logic [DATA_W-1:0]   rsp_rdata_q;
  logic [SEL_W-1:0]    rsp_bank_q;

  logic [SEL_W-1:0]    bank_sel;
  logic [WORD_W-1:0]   word_idx;
  logic [NUM_BANKS-1:0] bank_en;
  logic [DATA_W-1:0]   bank_rdata [NUM_BANKS];
  logic [DATA_W-1:0]   rd_data;
  logic                req_acc;
  logic                rd_acc;
  logic                wr_acc;

  // Upper address bits pick the bank; with a single bank there are no select bits.
  if (BANK_W > 0) begin : g_sel
    assign bank_sel = req_addr[ADDR_W-1 -: SEL_W];
  end else begin : g_nosel
    assign bank_sel = '0;
  end

  assign word_idx  = req_addr[WORD_W-1:0];
  assign req_ready = (state_q == EMPTY) || rsp_ready;
  assign req_acc   = req_valid && req_ready;
  assign rd_acc    = req_acc && !req_rw;
  assign wr_acc    = req_acc && req_rw;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [DATA_W-1:0] mem [BANK_DEPTH];

    assign bank_en[b]    = (bank_sel == SEL_W'(b));
    assign bank_rdata[b] = mem[word_idx];

    // Byte-masked write into the selected bank only; an edge that sees reset writes nothing.
    always_ff @(posedge clk or posedge rst) begin
      if (!rst && wr_acc && bank_en[b]) begin
        for (int i = 0; i < BE_W; i++) begin
          if (req_be[i]) begin
            mem[word_idx][8*i +: 8] <= req_wdata[8*i +: 8];
          end
        end
      end
    end
  end

  // Steer the addressed bank's word onto the shared read path.
  always_comb begin
    rd_data = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (bank_en[b]) begin
        rd_data = bank_rdata[b];
      end
    end
  end

  // Response buffer FSM: EMPTY/FULL with registered data and bank; data persists after drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= EMPTY;
      rsp_rdata_q <= '0;
      rsp_bank_q  <= '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (rd_acc) begin
            state_q     <= FULL;
            rsp_rdata_q <= rd_data;
            rsp_bank_q  <= bank_sel;
          end
        end
        FULL: begin
          if (rd_acc) begin
            rsp_rdata_q <= rd_data;
            rsp_bank_q  <= bank_sel;
          end else if (rsp_ready) begin
            state_q <= EMPTY;
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

  assign rsp_valid = (state_q == FULL);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_bank  = rsp_bank_q;

endmodule

// File: tb/tb_banked_ram_ctrl.sv
// Scoreboard bench for banked_ram_ctrl: default 32x64x4 instance plus a 16x16x2 instance.
// Stimulus pushes expected read responses; negedge monitors pop on each accepted response.
// Reset flushes the expected queue since pending responses are discarded.
module tb_banked_ram_ctrl;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  // Default-parameter instance
  logic        a_req_valid, a_req_ready, a_req_rw;
  logic [7:0]  a_req_addr;
  logic [31:0] a_req_wdata;
  logic [3:0]  a_req_be;
  logic        a_rsp_valid, a_rsp_ready;
  logic [31:0] a_rsp_rdata;
  logic [1:0]  a_rsp_bank;

  // DATA_W=16, BANK_DEPTH=16, NUM_BANKS=2 instance
  logic        b_req_valid, b_req_ready, b_req_rw;
  logic [4:0]  b_req_addr;
  logic [15:0] b_req_wdata;
  logic [1:0]  b_req_be;
  logic        b_rsp_valid, b_rsp_ready;
  logic [15:0] b_rsp_rdata;
  logic [0:0]  b_rsp_bank;

  banked_ram_ctrl u_dut_a (
    .clk(clk), .rst(rst),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_rw(a_req_rw),
    .req_addr(a_req_addr), .req_wdata(a_req_wdata), .req_be(a_req_be),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready),
    .rsp_rdata(a_rsp_rdata), .rsp_bank(a_rsp_bank)
  );

  banked_ram_ctrl #(.DATA_W(16), .BANK_DEPTH(16), .NUM_BANKS(2)) u_dut_b (
    .clk(clk), .rst(rst),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_rw(b_req_rw),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_be(b_req_be),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
    .rsp_rdata(b_rsp_rdata), .rsp_bank(b_rsp_bank)
  );

  typedef struct {
    logic [31:0] data;
    logic [1:0]  bank;
  } exp_t;

  exp_t a_q[$];
  exp_t b_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor A: every response consumed by the bench is compared against the queue head.
  always @(negedge clk) begin : mon_a
    exp_t e;
    if (!rst && a_rsp_valid && a_rsp_ready) begin
      if (a_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL a_unexpected_rsp: got 0x%0h expected no response", a_rsp_rdata);
      end else begin
        e = a_q.pop_front();
        check("a_rdata", a_rsp_rdata, e.data);
        check("a_bank", {30'd0, a_rsp_bank}, {30'd0, e.bank});
      end
    end
  end

  // Monitor B: same scheme for the narrow instance.
  always @(negedge clk) begin : mon_b
    exp_t e;
    if (!rst && b_rsp_valid && b_rsp_ready) begin
      if (b_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL b_unexpected_rsp: got 0x%0h expected no response", b_rsp_rdata);
      end else begin
        e = b_q.pop_front();
        check("b_rdata", {16'd0, b_rsp_rdata}, e.data);
        check("b_bank", {31'd0, b_rsp_bank}, {31'd0, e.bank[0]});
      end
    end
  end

  // Issue one request on A; waits (bounded) for req_ready, returns #1 after the accept edge.
  task automatic a_req(input logic rw, input logic [7:0] addr, input logic [31:0] wd,
                       input logic [3:0] be, input logic [31:0] ed, input logic [1:0] eb);
    int n = 0;
    a_req_valid = 1'b1; a_req_rw = rw; a_req_addr = addr; a_req_wdata = wd; a_req_be = be;
    @(negedge clk);
    while (!a_req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!a_req_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL a_req_timeout: got req_ready=0 expected 1 within 50 cycles");
    end else if (!rw) begin
      a_q.push_back('{ed, eb});
    end
    @(posedge clk);
    #1;
    a_req_valid = 1'b0;
  endtask

  task automatic b_req(input logic rw, input logic [4:0] addr, input logic [15:0] wd,
                       input logic [1:0] be, input logic [15:0] ed, input logic eb);
    int n = 0;
    b_req_valid = 1'b1; b_req_rw = rw; b_req_addr = addr; b_req_wdata = wd; b_req_be = be;
    @(negedge clk);
    while (!b_req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!b_req_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL b_req_timeout: got req_ready=0 expected 1 within 50 cycles");
    end else if (!rw) begin
      b_q.push_back('{{16'd0, ed}, {1'b0, eb}});
    end
    @(posedge clk);
    #1;
    b_req_valid = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000 time units");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    a_req_valid = 0; a_req_rw = 0; a_req_addr = 0; a_req_wdata = 0; a_req_be = 0; a_rsp_ready = 1;
    b_req_valid = 0; b_req_rw = 0; b_req_addr = 0; b_req_wdata = 0; b_req_be = 0; b_rsp_ready = 1;

    // Reset state, observed before the first clock edge
    #2;
    check("rst_a_valid", a_rsp_valid, 0);
    check("rst_a_rdata", a_rsp_rdata, 0);
    check("rst_a_bank", a_rsp_bank, 0);
    check("rst_a_ready", a_req_ready, 1);
    check("rst_b_valid", b_rsp_valid, 0);
    check("rst_b_rdata", b_rsp_rdata, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // One word per bank, including the all-ones address
    a_req(1, 8'h00, 32'hDEADBEEF, 4'hF, 0, 0);
    a_req(1, 8'h40, 32'hDEADBEEF, 4'hF, 0, 0);
    a_req(1, 8'h80, 32'hDEADBEEF, 4'hF, 0, 0);
    a_req(1, 8'hFF, 32'hDEADBEEF, 4'hF, 0, 0);
    a_req(0, 8'h00, 0, 0, 32'hDEADBEEF, 2'd0);
    check("lat_bank0", a_rsp_valid, 1);
    a_req(0, 8'h40, 0, 0, 32'hDEADBEEF, 2'd1);
    check("lat_bank1", a_rsp_valid, 1);
    a_req(0, 8'h80, 0, 0, 32'hDEADBEEF, 2'd2);
    check("lat_bank2", a_rsp_valid, 1);
    a_req(0, 8'hFF, 0, 0, 32'hDEADBEEF, 2'd3);
    check("lat_bank3", a_rsp_valid, 1);
    repeat (3) @(posedge clk);
    #1;

    // Byte enables: partial merge, then an all-zero enable write that must change nothing
    a_req(1, 8'h05, 32'h11223344, 4'hF, 0, 0);
    a_req(1, 8'h05, 32'hAABBCCDD, 4'b0101, 0, 0);
    a_req(0, 8'h05, 0, 0, 32'h11BB33DD, 2'd0);
    a_req(1, 8'h05, 32'hFFFFFFFF, 4'h0, 0, 0);
    a_req(0, 8'h05, 0, 0, 32'h11BB33DD, 2'd0);
    a_req(1, 8'h06, 32'hCAFEF00D, 4'hF, 0, 0);
    repeat (2) @(posedge clk);
    #1;

    // Back-pressure: response held, pending request blocked for 3 cycles
    a_rsp_ready = 1'b0;
    a_req(0, 8'h05, 0, 0, 32'h11BB33DD, 2'd0);
    a_req_valid = 1'b1; a_req_rw = 1'b0; a_req_addr = 8'h06;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_ready", a_req_ready, 0);
      check("hold_valid", a_rsp_valid, 1);
      check("hold_rdata", a_rsp_rdata, 32'h11BB33DD);
    end
    @(posedge clk);
    #1;
    a_rsp_ready = 1'b1;
    a_q.push_back('{32'hCAFEF00D, 2'd0});
    @(posedge clk);
    #1;
    a_req_valid = 1'b0;
    check("b2b_valid", a_rsp_valid, 1);
    @(posedge clk);
    #1;
    check("drain_valid", a_rsp_valid, 0);
    check("drain_keeps_rdata", a_rsp_rdata, 32'hCAFEF00D);

    // Write accepted while draining a response empties the buffer
    a_req(0, 8'h00, 0, 0, 32'hDEADBEEF, 2'd0);
    a_req(1, 8'h07, 32'h01020304, 4'hF, 0, 0);
    check("wr_drain_valid", a_rsp_valid, 0);
    a_req(0, 8'h07, 0, 0, 32'h01020304, 2'd0);
    repeat (2) @(posedge clk);
    #1;

    // Reset mid-cycle with a pending response; a write coinciding with reset is dropped
    a_req(1, 8'h3F, 32'h12345678, 4'hF, 0, 0);
    a_rsp_ready = 1'b0;
    a_req(0, 8'h05, 0, 0, 32'h11BB33DD, 2'd0);
    #3;
    rst = 1'b1;
    a_q.delete();
    #1;
    check("arst_valid", a_rsp_valid, 0);
    check("arst_rdata", a_rsp_rdata, 0);
    check("arst_bank", a_rsp_bank, 0);
    check("arst_ready", a_req_ready, 1);
    a_rsp_ready = 1'b1;
    a_req_valid = 1'b1; a_req_rw = 1'b1; a_req_addr = 8'h3F; a_req_wdata = 32'hFFFFFFFF; a_req_be = 4'hF;
    @(posedge clk);
    #1;
    a_req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    a_req(0, 8'h3F, 0, 0, 32'h12345678, 2'd0);
    repeat (2) @(posedge clk);
    #1;

    // Narrow instance: top address in bank 1, last word of bank 0, and a byte-lane merge
    b_req(1, 5'h1F, 16'hA5A5, 2'b11, 0, 0);
    b_req(1, 5'h0F, 16'h1234, 2'b11, 0, 0);
    b_req(0, 5'h1F, 0, 0, 16'hA5A5, 1'b1);
    b_req(0, 5'h0F, 0, 0, 16'h1234, 1'b0);
    b_req(1, 5'h0F, 16'hFF00, 2'b10, 0, 0);
    b_req(0, 5'h0F, 0, 0, 16'hFF34, 1'b0);

    repeat (4) @(posedge clk);
    #1;
    check("a_queue_empty", a_q.size(), 0);
    check("b_queue_empty", b_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
